// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: glitch-filtered frame capture, make/break/E0 decode, event FIFO.
// Latency: event visible one clk after the stop-bit edge is taken; consumer drains via valid/ready.
module ps2_kbd_fifo #(
    parameter int FILT_LEN    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int REPORT_MAKE = 1,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              ps2clk_i,
    input  logic                              ps2data_i,
    output logic [7:0]                        code_o,
    output logic                              brk_o,
    output logic                              ext_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              err_o,
    output logic                              ovf_o
);
    localparam int HALF = FILT_LEN / 2;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic [1:0]          clk_sync_q, dat_sync_q;
    logic [FILT_LEN-1:0] hist_q;
    logic                fall_edge;
    logic                ps2d;

    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_stb_q, rx_stb_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          err_q, err_d;
    logic          frame_good;

    state_t state_q, state_d;
    logic   emit, ev_ext, ev_brk, push;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full, valid, pop, wr_en;
    logic [9:0]    head;

    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            hist_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2data_i};
            hist_q     <= {hist_q[FILT_LEN-2:0], clk_sync_q[1]};
        end
    end

    assign ps2d      = dat_sync_q[1];
    assign fall_edge = (&hist_q[FILT_LEN-1:HALF]) && !(|hist_q[HALF-1:0]);

    // frame_q fills from the top: after ten edges [0]=start, [8:1]=data, [9]=parity.
    assign frame_good = !frame_q[0] && ps2d && (^frame_q[9:1]);

    always_comb begin
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        tmo_d     = tmo_q;
        rx_stb_d  = 1'b0;
        rx_byte_d = rx_byte_q;
        err_d     = 1'b0;
        if (fall_edge) begin
            tmo_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d  = 4'd0;
                rx_stb_d  = frame_good;
                err_d     = !frame_good;
                rx_byte_d = frame_q[8:1];
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
                frame_d  = {ps2d, frame_q[9:1]};
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_d    = '0;
                bitcnt_d = 4'd0;
                err_d    = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bitcnt_q  <= '0;
            frame_q   <= '0;
            tmo_q     <= '0;
            rx_stb_q  <= 1'b0;
            rx_byte_q <= '0;
            err_q     <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            bitcnt_q  <= bitcnt_d;
            frame_q   <= frame_d;
            tmo_q     <= tmo_d;
            rx_stb_q  <= rx_stb_d;
            rx_byte_q <= rx_byte_d;
            err_q     <= err_d;
            state_q   <= state_d;
        end
    end

    // err_q doubles as the decoder abort: a bad frame or timeout discards any pending prefix.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (err_q) begin
            state_d = S_IDLE;
        end else if (rx_stb_q) begin
            case (state_q)
                S_IDLE: begin
                    case (rx_byte_q)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = S_IDLE;
                        default: emit = 1'b1;
                    endcase
                end
                S_EXT: begin
                    case (rx_byte_q)
                        8'hF0: state_d = S_EXT_BRK;
                        8'hE0: state_d = S_EXT;
                        default: begin
                            emit    = 1'b1;
                            ev_ext  = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
                S_BRK: begin
                    emit    = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    emit    = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign push  = emit && (ev_brk || (REPORT_MAKE != 0));
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign valid = (count_q != '0);
    assign pop   = valid && ready_i;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {ev_ext, ev_brk, rx_byte_q};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage is not reset, so the head is masked until an entry exists.
    assign head    = valid ? mem_q[rd_ptr_q] : 10'd0;
    assign code_o  = head[7:0];
    assign brk_o   = head[8];
    assign ext_o   = head[9];
    assign valid_o = valid;
    assign count_o = count_q;
    assign err_o   = err_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed bench for ps2_kbd_fifo: a make+break instance and a break-only instance share the pins.
module tb_ps2_kbd_fifo;
    localparam int FL = 8;
    localparam int FD = 4;
    localparam int TO = 200;
    localparam int HB = 20;

    logic       clk = 1'b0;
    logic       rst_n, ps2clk, ps2data, ready, ready0;
    logic [7:0] code, code0;
    logic       brk, ext, valid, err, ovf;
    logic       brk0, ext0, valid0, err0, ovf0;
    logic [2:0] count, count0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_fall = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end

    ps2_kbd_fifo #(.FILT_LEN(FL), .FIFO_DEPTH(FD), .REPORT_MAKE(1), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .reset_ni(rst_n), .ps2clk_i(ps2clk), .ps2data_i(ps2data),
        .code_o(code), .brk_o(brk), .ext_o(ext), .valid_o(valid), .ready_i(ready),
        .count_o(count), .err_o(err), .ovf_o(ovf));

    ps2_kbd_fifo #(.FILT_LEN(FL), .FIFO_DEPTH(FD), .REPORT_MAKE(0), .TIMEOUT_CYC(TO)) dut0 (
        .clk_i(clk), .reset_ni(rst_n), .ps2clk_i(ps2clk), .ps2data_i(ps2data),
        .code_o(code0), .brk_o(brk0), .ext_o(ext0), .valid_o(valid0), .ready_i(ready0),
        .count_o(count0), .err_o(err0), .ovf_o(ovf0));

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2data = b;
        repeat (HB / 2) @(negedge clk);
        ps2clk = 1'b0;
        last_fall = cyc;
        repeat (HB) @(negedge clk);
        ps2clk = 1'b1;
        repeat (HB / 2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(f[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mkframe(b, 1'b0), 0, 10);
        repeat (10) @(negedge clk);
    endtask

    task automatic pop1;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ps2clk = 1'b1; ps2data = 1'b1; ready = 1'b0; ready0 = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({code, brk, ext, valid, count, err, ovf} !== 15'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {code, brk, ext, valid, count, err, ovf}); end
        total++; if ({code0, brk0, ext0, valid0, count0, err0, ovf0} !== 15'd0) begin bad++; $display("FAIL reset_outputs0 got=%h exp=0", {code0, brk0, ext0, valid0, count0, err0, ovf0}); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_make_break;
        send_byte(8'h1C);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL mb_count1 got=%0d exp=1", count); end
        total++; if ({ext, brk, code} !== 10'h01C) begin bad++; $display("FAIL mb_head1 got=%h exp=01c", {ext, brk, code}); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL mb_count2 got=%0d exp=2", count); end
        total++; if ({ext, brk, code} !== 10'h01C) begin bad++; $display("FAIL mb_head_kept got=%h exp=01c", {ext, brk, code}); end
        pop1;
        total++; if ({valid, count, ext, brk, code} !== {1'b1, 3'd1, 10'h11C}) begin bad++; $display("FAIL mb_head2 got=%h exp=%h", {valid, count, ext, brk, code}, {1'b1, 3'd1, 10'h11C}); end
        pop1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL mb_empty got=%b exp=0", valid); end
        send_byte(8'hFA);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ack_dropped got=%0d exp=0", count); end
    endtask

    task automatic test_ext;
        ready0 = 1'b0;
        send_byte(8'hE0);
        send_byte(8'h75);
        total++; if ({count, ext, brk, code} !== {3'd1, 10'h275}) begin bad++; $display("FAIL ext_make got=%h exp=%h", {count, ext, brk, code}, {3'd1, 10'h275}); end
        total++; if (count0 !== 3'd0) begin bad++; $display("FAIL ext_make_nomake got=%0d exp=0", count0); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL ext_brk_count got=%0d exp=2", count); end
        total++; if ({count0, ext0, brk0, code0} !== {3'd1, 10'h375}) begin bad++; $display("FAIL ext_brk_nomake got=%h exp=%h", {count0, ext0, brk0, code0}, {3'd1, 10'h375}); end
        pop1;
        total++; if ({ext, brk, code} !== 10'h375) begin bad++; $display("FAIL ext_brk_head got=%h exp=375", {ext, brk, code}); end
        pop1;
        ready0 = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({valid, valid0} !== 2'b00) begin bad++; $display("FAIL ext_drained got=%b exp=00", {valid, valid0}); end
    endtask

    task automatic test_parity;
        int e0;
        e0 = err_cnt;
        send_bits(mkframe(8'h1C, 1'b1), 0, 10);
        repeat (10) @(negedge clk);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL parity_noevent got=%0d exp=0", count); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if ({count, ext, brk, code} !== {3'd1, 10'h11C}) begin bad++; $display("FAIL parity_recover got=%h exp=%h", {count, ext, brk, code}, {3'd1, 10'h11C}); end
        pop1;
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_bits(mkframe(8'h16, 1'b0), 0, 4);
        for (int i = 0; i < TO + 100 && err_cnt == e0; i++) @(negedge clk);
        total++; if (err_cnt == e0) begin bad++; $display("FAIL timeout_seen got=none exp=err pulse"); end
        // Pin-to-edge lag is 2 sync + FL/2 filter cycles, plus one edge to register the counter clear.
        total++; if (err_cyc - last_fall !== TO + FL / 2 + 3) begin bad++; $display("FAIL timeout_delay got=%0d exp=%0d", err_cyc - last_fall, TO + FL / 2 + 3); end
        repeat (5) @(negedge clk);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_width got=%0d exp=1", err_cnt - e0); end
        send_byte(8'h16);
        total++; if ({count, ext, brk, code} !== {3'd1, 10'h016}) begin bad++; $display("FAIL timeout_recover got=%h exp=%h", {count, ext, brk, code}, {3'd1, 10'h016}); end
        pop1;
    endtask

    task automatic test_overflow;
        logic [7:0] codes [5];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_initial got=%b exp=0", ovf); end
        for (int i = 0; i < 5; i++) send_byte(codes[i]);
        total++; if ({count, ovf} !== {3'd4, 1'b1}) begin bad++; $display("FAIL ovf_full got=%h exp=%h", {count, ovf}, {3'd4, 1'b1}); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({valid, ext, brk, code} !== {1'b1, 2'b00, codes[i]}) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, {valid, ext, brk, code}, {1'b1, 2'b00, codes[i]}); end
            pop1;
        end
        total++; if ({valid, count, ovf} !== {1'b0, 3'd0, 1'b1}) begin bad++; $display("FAIL ovf_after got=%h exp=%h", {valid, count, ovf}, {1'b0, 3'd0, 1'b1}); end
    endtask

    task automatic test_mid_reset;
        int e0;
        logic [10:0] f;
        f = mkframe(8'h2A, 1'b0);
        send_byte(8'h1C);
        send_bits(f, 0, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({code, brk, ext, valid, count, err, ovf} !== 15'd0) begin bad++; $display("FAIL midreset_outputs got=%h exp=0", {code, brk, ext, valid, count, err, ovf}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = err_cnt;
        send_bits(f, 6, 10);
        for (int i = 0; i < TO + 100 && err_cnt == e0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL midreset_tail_err got=%0d exp=1", err_cnt - e0); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL midreset_tail_noevent got=%0d exp=0", count); end
        send_byte(8'h45);
        total++; if ({count, ext, brk, code} !== {3'd1, 10'h045}) begin bad++; $display("FAIL midreset_recover got=%h exp=%h", {count, ext, brk, code}, {3'd1, 10'h045}); end
        pop1;
    endtask

    initial begin
        test_reset;
        test_make_break;
        test_ext;
        test_parity;
        test_timeout;
        test_overflow;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
